uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side buffer between `uart_rx` and the byte consumer. Collects each completed frame from `uart_rx` together with its parity and framing error flags, and returns the one-cycle `i_byte_accept` acknowledge to the receiver. Frames are stored in a first-word-fall-through FIFO that the consumer drains over a valid/ready handshake. Error-flagged frames are counted in a saturating status counter.

## Interface
Parameters:
- `depth`, 16, number of entries; power of two, ≥ 2
- `ptr_width`, `$clog2(depth)`, derived; do not override

Ports:
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_rx_done`  in  1  from `uart_rx.o_done`; held high until acknowledged
- `i_rx_data`  in  8  from `uart_rx.o_data_byte`
- `i_rx_parity_error`  in  1  from `uart_rx.parity_error`
- `i_rx_framing_error`  in  1  from `uart_rx.framing_error`
- `o_rx_accept`  out  1  to `uart_rx.i_byte_accept`; one-cycle pulse
- `o_valid`  out  1  head entry available
- `o_data`  out  8  head entry data
- `o_parity_error`  out  1  head entry parity flag
- `o_framing_error`  out  1  head entry framing flag
- `i_ready`  in  1  consumer takes the head entry when `o_valid` is also high
- `o_count`  out  ptr_width+1  entries stored
- `o_full`  out  1  `o_count == depth`
- `o_err_count`  out  8  saturating count of stored frames with either error flag set
- `i_clr_err`  in  1  synchronous clear of `o_err_count`

## Operation
- Capture FSM has two states.
  - IDLE: when `i_rx_done && !o_full`, write {flags, data} at `wr_ptr`, increment `wr_ptr`, register `o_rx_accept`=1, and go to WAIT_CLR.
  - WAIT_CLR: `o_rx_accept`=0. Stay while `i_rx_done`=1. Return to IDLE on `i_rx_done`=0.
  - WAIT_CLR guarantees exactly one write per frame, even though `o_done` persists for a cycle after the accept pulse.
- Full: no write and no accept. The frame stays held in `uart_rx`, so back-pressure is applied by withholding the acknowledge. The capture proceeds in the first cycle in which `!o_full`.
- Read: when `o_valid && i_ready`, increment `rd_ptr`. `o_data` and the flags are a combinational read of `mem[rd_ptr]`.
- Simultaneous write and read: both occur and `o_count` is unchanged. The full decision uses the current-cycle `o_full`; there is no pass-through write when full with a read in the same cycle.
- Pointers are `ptr_width` bits and wrap modulo `depth`. `o_count` is a separate up/down counter.
- `o_err_count` increments on each write whose parity or framing flag is set, and saturates at 255. `i_clr_err` has priority over a same-cycle increment and gives 0.
- Reset mid-operation: pointers, count, state, `o_rx_accept` and `o_err_count` all go to 0 and stored entries are discarded. A frame still pending in `uart_rx` after reset is captured as new.

## Timing
- Reset values: `o_rx_accept`=0, `o_valid`=0, `o_count`=0, `o_full`=0, `o_err_count`=0. `o_data` and the flags are don't-care while `o_valid`=0.
- Capture at cycle T (IDLE, `i_rx_done`=1, not full):
  - `o_rx_accept`=1 in cycle T+1 only.
  - The entry is visible, with `o_valid`=1 if the FIFO was empty, in T+1.
  - `o_count` updates in T+1.
- Minimum spacing between captures is 3 cycles (T, accept at T+1, `i_rx_done` low at T+2, IDLE at T+3). This is far below one UART frame.
- Read at cycle R: the next head entry, or `o_valid`=0, appears in R+1.
- `o_full`, `o_valid` and `o_count` are registered-state-derived and have no combinational path from `i_ready` or `i_rx_done`.

## Structure
- `uart_pkg` holds:
  - the entry layout constants: `UART_ENTRY_W`=10, data [7:0], parity [8], framing [9]
  - the capture state encoding `RXF_IDLE`/`RXF_WAIT_CLR`
- Sub-module `uart_fifo_ram`: `depth` × `UART_ENTRY_W` register array with a synchronous write port and an asynchronous read port. It has no reset, and its contents are undefined until written.
- `uart_rx_fifo` owns the FSM, pointers, counters and flags.

## Test plan
- Loopback through `uart_tx` → `uart_rx` → `uart_rx_fifo`, sending 0xAA, 0x55, 0xA5 with `i_ready`=0:
  - `o_count`=3 and exactly three `o_rx_accept` pulses.
  - Then with `i_ready`=1, the outputs are AA, 55, A5 in order with both flags 0.
- Drive `i_rx_done` high with data 0x3C for 5 cycles, then low: exactly one entry with data 0x3C and one accept pulse 1 cycle after the rising edge.
- Fill to `depth`=16 with 0x00–0x0F, then present 0xC3 with `i_rx_done` held high:
  - No accept while full.
  - Pop one entry: 0xC3 is accepted within 2 cycles and the final output order is 0x01…0x0F, 0xC3.
- Capture and read in the same cycle with `o_count`=4: `o_count` stays 4 and the data order is preserved.
- Inject 300 frames with `i_rx_framing_error`=1 and draining enabled: `o_err_count`=255. Assert `i_clr_err` and pulse a frame in the same cycle: `o_err_count`=0.
- Assert `i_rst_n`=0 with 5 entries stored, mid-capture: all outputs return to reset values, then the next frame is stored as the sole entry.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: entry layout and capture FSM states.
package uart_pkg;

  localparam int UART_ENTRY_W  = 10;
  localparam int UART_DATA_MSB = 7;
  localparam int UART_PAR_BIT  = 8;
  localparam int UART_FRM_BIT  = 9;

  typedef enum logic {
    RXF_IDLE     = 1'b0,
    RXF_WAIT_CLR = 1'b1
  } rxf_state_t;

  function automatic logic [UART_ENTRY_W-1:0] uart_pack_entry(
    input logic [7:0] data,
    input logic       parity_err,
    input logic       framing_err
  );
    return {framing_err, parity_err, data};
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_ram #(
  parameter int depth     = 16,
  parameter int width     = 10,
  parameter int ptr_width = $clog2(depth)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ptr_width-1:0] i_waddr,
  input  logic [width-1:0]     i_wdata,
  input  logic [ptr_width-1:0] i_raddr,
  output logic [width-1:0]     o_rdata
);

  logic [width-1:0] r_mem [depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer: acknowledges completed frames from uart_rx, stores them with
// their error flags in a first-word-fall-through FIFO, and counts errored frames.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int depth     = 16,
  parameter int ptr_width = $clog2(depth)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rx_done,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_parity_error,
  input  logic               i_rx_framing_error,
  output logic               o_rx_accept,
  output logic               o_valid,
  output logic [7:0]         o_data,
  output logic               o_parity_error,
  output logic               o_framing_error,
  input  logic               i_ready,
  output logic [ptr_width:0] o_count,
  output logic               o_full,
  output logic [7:0]         o_err_count,
  input  logic               i_clr_err
);

  localparam logic [ptr_width:0] CNT_FULL = (ptr_width + 1)'(depth);

  rxf_state_t              r_state;
  rxf_state_t              w_state_nxt;
  logic                    w_wr_en;
  logic                    w_rd_en;
  logic [ptr_width-1:0]    r_wr_ptr;
  logic [ptr_width-1:0]    r_rd_ptr;
  logic [ptr_width:0]      r_count;
  logic                    r_accept;
  logic [7:0]              r_err_count;
  logic [UART_ENTRY_W-1:0] w_wr_entry;
  logic [UART_ENTRY_W-1:0] w_rd_entry;

  assign o_valid     = (r_count != '0);
  assign o_full      = (r_count == CNT_FULL);
  assign o_count     = r_count;
  assign o_rx_accept = r_accept;
  assign o_err_count = r_err_count;

  assign w_rd_en    = o_valid && i_ready;
  assign w_wr_entry = uart_pack_entry(i_rx_data, i_rx_parity_error, i_rx_framing_error);

  // WAIT_CLR absorbs the cycle in which o_done is still high after the accept pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    case (r_state)
      RXF_IDLE: begin
        if (i_rx_done && !o_full) begin
          w_wr_en     = 1'b1;
          w_state_nxt = RXF_WAIT_CLR;
        end
      end
      RXF_WAIT_CLR: begin
        if (!i_rx_done) begin
          w_state_nxt = RXF_IDLE;
        end
      end
      default: w_state_nxt = RXF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= RXF_IDLE;
      r_accept <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_accept <= w_wr_en;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_count <= '0;
    end else if (i_clr_err) begin
      r_err_count <= '0;
    end else if (w_wr_en && (i_rx_parity_error || i_rx_framing_error)
                 && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  uart_fifo_ram #(
    .depth     (depth),
    .width     (UART_ENTRY_W),
    .ptr_width (ptr_width)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  assign o_data          = w_rd_entry[UART_DATA_MSB:0];
  assign o_parity_error  = w_rd_entry[UART_PAR_BIT];
  assign o_framing_error = w_rd_entry[UART_FRM_BIT];

endmodule
